// File: rtl/divider.sv
// Sequential radix-2 restoring divider: one quotient bit per clock.
// Signed or unsigned, fixed 33-cycle latency from start to valid.
module divider #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             is_zero,
    output logic             is_negative
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             bz_q, bz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             valid_q, valid_d;
    logic             dbz_q, dbz_d;

    // 33-bit partial remainder keeps |INT_MIN| exact
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        a_orig_d = a_orig_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        bz_d     = bz_q;
        quot_d   = quot_q;
        rmd_d    = rmd_q;
        dbz_d    = dbz_q;
        valid_d  = 1'b0;
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        diff     = shifted - {1'b0, dsr_q};

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d    = '0;
                    dvd_d    = (is_signed && a[WIDTH-1]) ? -a : a;
                    dsr_d    = (is_signed && b[WIDTH-1]) ? -b : b;
                    q_neg_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_neg_d  = is_signed & a[WIDTH-1];
                    bz_d     = (b == '0);
                    a_orig_d = a;
                    cnt_d    = CNTW'(WIDTH - 1);
                    state_d  = S_DIV;
                end
            end
            S_DIV: begin
                if (shifted >= {1'b0, dsr_q}) begin
                    rem_d = diff[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (bz_q) begin
                    quot_d = '1;
                    rmd_d  = a_orig_q;
                end else begin
                    quot_d = q_neg_q ? -dvd_q : dvd_q;
                    rmd_d  = r_neg_q ? -rem_q : rem_q;
                end
                dbz_d   = bz_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            a_orig_q <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            bz_q     <= 1'b0;
            quot_q   <= '0;
            rmd_q    <= '0;
            valid_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            a_orig_q <= a_orig_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            bz_q     <= bz_d;
            quot_q   <= quot_d;
            rmd_q    <= rmd_d;
            valid_q  <= valid_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign valid       = valid_q;
    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;
    assign is_zero     = (quot_q == '0);
    assign is_negative = quot_q[WIDTH-1];

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: vector table plus handshake
// and reset sequences, all expectations hand-computed.
module tb_divider;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        valid;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        is_zero;
    logic        is_negative;

    int n_cmp = 0;
    int n_bad = 0;

    divider dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .is_zero     (is_zero),
        .is_negative (is_negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // called at a negedge; the following posedge accepts the request
    task automatic launch(input logic [31:0] va, input logic [31:0] vb,
                          input logic vs);
        a         = va;
        b         = vb;
        is_signed = vs;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        a         = 32'h0BAD_F00D;
        b         = 32'h0000_0011;
        is_signed = ~vs;
    endtask

    task automatic wait_result(input string nm, input logic [31:0] eq,
                               input logic [31:0] er, input logic edz,
                               input int poke);
        int  k;
        bit  busy_ok;
        k       = 40;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (poke != 0 && i == poke) begin
                start     = 1'b1;
                a         = 32'h0000_0032;
                b         = 32'h0000_0005;
                is_signed = 1'b1;
            end else if (poke != 0 && i == poke + 1) begin
                start = 1'b0;
            end
            if (valid) begin
                k = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        chk({nm, ".latency"}, 32'(k), 32'd33);
        chk({nm, ".busy_during"}, {31'd0, busy_ok}, 32'd1);
        chk({nm, ".valid"}, {31'd0, valid}, 32'd1);
        chk({nm, ".busy_at_valid"}, {31'd0, busy}, 32'd0);
        chk({nm, ".quotient"}, quotient, eq);
        chk({nm, ".remainder"}, remainder, er);
        chk({nm, ".div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
        chk({nm, ".is_zero"}, {31'd0, is_zero}, {31'd0, (eq == 32'd0)});
        chk({nm, ".is_negative"}, {31'd0, is_negative}, {31'd0, eq[31]});
    endtask

    task automatic no_valid(input string nm, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid) cnt++;
        end
        chk({nm, ".no_valid"}, 32'(cnt), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0};
        vecs[1]  = '{32'hFFFFFF9C, 32'd7, 1'b1,
                     32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        vecs[2]  = '{32'd100, 32'hFFFFFFF9, 1'b1,
                     32'hFFFFFFF2, 32'd2, 1'b0};
        vecs[3]  = '{32'h12345678, 32'd0, 1'b1,
                     32'hFFFFFFFF, 32'h12345678, 1'b1};
        vecs[4]  = '{32'h12345678, 32'd0, 1'b0,
                     32'hFFFFFFFF, 32'h12345678, 1'b1};
        vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1,
                     32'h80000000, 32'd0, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'd1, 1'b0,
                     32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[7]  = '{32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0};
        vecs[8]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1,
                     32'd3, 32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0,
                     32'd0, 32'h80000000, 1'b0};
        vecs[10] = '{32'hFFFFFF9C, 32'd0, 1'b1,
                     32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1};

        resetn    = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.valid", {31'd0, valid}, 32'd0);
        chk("reset.quotient", quotient, 32'd0);
        chk("reset.remainder", remainder, 32'd0);
        chk("reset.div_by_zero", {31'd0, div_by_zero}, 32'd0);
        chk("reset.is_zero", {31'd0, is_zero}, 32'd1);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r,
                        vecs[i].dz, 0);
            @(negedge clk);
        end

        // restart while busy must be dropped, not queued
        launch(32'd100, 32'd7, 1'b0);
        wait_result("midop", 32'd14, 32'd2, 1'b0, 10);
        no_valid("midop.after", 36);

        // start in the valid cycle is taken with no bubble
        launch(32'd1000, 32'd10, 1'b0);
        wait_result("b2b.first", 32'd100, 32'd0, 1'b0, 0);
        launch(32'hFFFFFFB3, 32'd7, 1'b1);
        wait_result("b2b.second", 32'hFFFFFFF5, 32'd0, 1'b0, 0);

        // async reset mid-operation abandons it
        @(negedge clk);
        launch(32'd1000, 32'd3, 1'b0);
        repeat (14) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midreset.busy", {31'd0, busy}, 32'd0);
        chk("midreset.valid", {31'd0, valid}, 32'd0);
        chk("midreset.quotient", quotient, 32'd0);
        chk("midreset.remainder", remainder, 32'd0);
        chk("midreset.div_by_zero", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        no_valid("midreset", 40);
        launch(32'd1000, 32'd3, 1'b0);
        wait_result("postreset", 32'd333, 32'd1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential 32-bit integer divider. Companion to the combinational ALU: the ALU builds its product from 16x16 partial products, and this block performs the inverse operation, division.
- Radix-2 restoring algorithm, one quotient bit per clock. Produces quotient and remainder, signed or unsigned.
- Sits beside the ALU in the CPU execute stage. The CPU asserts start, stalls on busy, and captures results on valid.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is verified.
- CNTW, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; accepted only when busy=0.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  input  32  dividend; sampled on the accepting edge.
- b  input  32  divisor; sampled on the accepting edge.
- busy  output  1  high while an operation is in progress.
- valid  output  1  one-cycle pulse: results updated.
- quotient  output  32  registered quotient; held until the next valid.
- remainder  output  32  registered remainder; held until the next valid.
- div_by_zero  output  1  registered; set with valid when the sampled b == 0.
- is_zero  output  1  quotient == 0 (combinational from quotient register).
- is_negative  output  1  quotient[31].

Behaviour:
- Reset, asynchronous, resetn low: state=IDLE; busy, valid, div_by_zero = 0; quotient, remainder, counter, all datapath registers = 0.
  - Reset mid-operation abandons the operation; no valid is produced.
- States: IDLE, DIV, FIX.
- IDLE:
  - On an edge with start=1, latch the operand magnitudes: |a| and |b| if is_signed, else raw a and b.
  - Latch the result signs: q_neg = a[31]^b[31], r_neg = a[31], both gated by is_signed. Latch bz = (b==0).
  - Clear the partial remainder, set counter=31, go to DIV. busy=1 from the next cycle.
- DIV, 32 edges:
  - Shift {rem,dvd} left 1.
  - If rem_shifted >= divisor: rem -= divisor, quotient bit = 1; else quotient bit = 0.
  - Use a 33-bit compare/subtract so a dividend of 0x80000000 (magnitude of INT_MIN) is exact.
  - counter decrements; at counter==0, go to FIX.
- FIX, 1 edge:
  - quotient <= q_neg ? -q : q; remainder <= r_neg ? -r : r. Negation wraps modulo 2^32.
  - If bz: quotient <= 0xFFFFFFFF, remainder <= original a (sign fix suppressed).
  - div_by_zero <= bz; valid <= 1; busy <= 0; go to IDLE.
- Latency: start accepted at edge E0; valid and new results visible after edge E33, 33 cycles later. Fixed latency regardless of operand values, including divide-by-zero.
- valid is high exactly one cycle. busy is low in that same cycle.
- start=1 in the cycle valid is high is accepted (back-to-back operation, no bubble).
- start while busy=1 is ignored and not queued.
- Operand or is_signed changes after the accepting edge have no effect.
- Signed overflow: 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0, div_by_zero 0.
- Remainder sign follows the dividend; the quotient truncates toward zero.
- is_zero and is_negative track the quotient register, so they are stable between valid pulses.

Test Plan:
1. Reset released, a=100, b=7, is_signed=0, start pulse -> valid exactly 33 cycles after the accepting edge, quotient=14, remainder=2, div_by_zero=0; busy high for the intervening cycles.
2. Signed operands -> a=-100 (0xFFFFFF9C), b=7: quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2), is_negative=1. Then a=100, b=-7: quotient=-14, remainder=2.
3. Divide by zero, a=0x12345678, b=0, signed and unsigned -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, same 33-cycle latency.
4. Boundary cases:
   - Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
   - Unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
   - Unsigned 5/9 -> quotient 0, remainder 5, is_zero=1.
5. Handshake:
   - start re-pulsed mid-operation with different operands -> ignored, first result unchanged.
   - start held high in the valid cycle -> second operation accepted immediately, second valid 33 cycles later.
6. resetn pulsed low at cycle 15 of an operation -> outputs immediately zero, no valid pulse. A new start after release completes normally with correct results.
